spi_slave_frontend: RTL

SPI_SLAVE_FRONTEND -- requirements
Module: spi_slave_frontend

---
 rtl/spi_slave_frontend_if.sv | 24 ++
 rtl/spi_slave_frontend.sv | 110 +++++++++++
 2 files changed

// File: rtl/spi_slave_frontend_if.sv
// spi_slave_frontend_if: SPI pins, counter controls and receive outputs of the SPI slave front end
interface spi_slave_frontend_if;
  logic i_sck;
  logic i_mosi;
  logic i_cs_n;
  logic i_en_count;
  logic i_res_count;
  logic o_sck_rise;
  logic o_sck_fall;
  logic o_cs_start;
  logic o_count_f;
  logic [7:0] o_rx_byte;
  logic o_rx_valid;
  logic o_busy;
  logic o_frame_err;
  modport master (
    output i_sck, i_mosi, i_cs_n, i_en_count, i_res_count,
    input  o_sck_rise, o_sck_fall, o_cs_start, o_count_f, o_rx_byte, o_rx_valid, o_busy, o_frame_err
  );
  modport slave (
    input  i_sck, i_mosi, i_cs_n, i_en_count, i_res_count,
    output o_sck_rise, o_sck_fall, o_cs_start, o_count_f, o_rx_byte, o_rx_valid, o_busy, o_frame_err
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: mode-0 SPI receive front end; define SPI_SCK_GLITCH_FILTER_EN to add an SCK glitch filter
module spi_slave_frontend (
  input logic i_clk,
  input logic i_rst,
  spi_slave_frontend_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SELECT, RX} state_t;
  state_t state, state_n;
  logic sck_m, sck_s, sck_f, sck_d;
  logic mosi_m, mosi_s, mosi_d;
  logic cs_m, cs_s, cs_d;
  logic [1:0] live;
  logic armed, cs_fall, cs_rise;
  logic sck_rise, sck_fall;
  logic [2:0] cnt;
  logic [7:0] sh, rx_byte;
  logic rx_valid, count_f, frame_err, cs_start, busy;
  // synchronizers and registered SCK edge pulses; CS falls are ignored until CS has been seen high after reset
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
      mosi_d <= 1'b0;
      cs_m <= 1'b1;
      cs_s <= 1'b1;
      cs_d <= 1'b1;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      live <= 2'b00;
      armed <= 1'b0;
    end else begin
      sck_m <= bus.i_sck;
      sck_s <= sck_m;
      sck_d <= sck_f;
      mosi_m <= bus.i_mosi;
      mosi_s <= mosi_m;
      mosi_d <= mosi_s;
      cs_m <= bus.i_cs_n;
      cs_s <= cs_m;
      cs_d <= cs_s;
      sck_rise <= sck_f & ~sck_d;
      sck_fall <= ~sck_f & sck_d;
      live <= {live[0], 1'b1};
      armed <= armed | (live[1] & cs_s);
    end
`ifdef SPI_SCK_GLITCH_FILTER_EN
  // accept a new SCK level only once two consecutive synchronizer samples agree
  always_ff @(posedge i_clk)
    sck_f <= i_rst ? 1'b0 : (sck_m == sck_s ? sck_s : sck_f);
`else
  assign sck_f = sck_s;
`endif
  assign cs_fall = armed & cs_d & ~cs_s;
  assign cs_rise = cs_s & ~cs_d;
  // state register
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_n;
  // next state and state-decoded outputs
  always_comb begin
    state_n = state;
    cs_start = state == SELECT;
    busy = state != IDLE;
    if (state == IDLE && cs_fall) state_n = SELECT;
    else if (state == SELECT) state_n = RX;
    else if (state == RX && cs_rise) state_n = IDLE;
  end
  // shift register, bit counter and byte/abort pulses
  always_ff @(posedge i_clk)
    if (i_rst) begin
      cnt <= 3'd0;
      sh <= 8'h00;
      rx_byte <= 8'h00;
      rx_valid <= 1'b0;
      count_f <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      count_f <= 1'b0;
      frame_err <= 1'b0;
      if (state == SELECT) begin
        cnt <= 3'd0;
        sh <= 8'h00;
      end else if (state == RX && cs_rise) begin
        frame_err <= cnt != 3'd0;
        cnt <= 3'd0;
      end else begin
        if (state == RX && sck_rise) sh <= {sh[6:0], mosi_d};
        if (bus.i_res_count) cnt <= 3'd0;
        else if (state == RX && sck_rise && bus.i_en_count) begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            count_f <= 1'b1;
            rx_valid <= 1'b1;
            rx_byte <= {sh[6:0], mosi_d};
          end
        end
      end
    end
  assign bus.o_sck_rise = sck_rise;
  assign bus.o_sck_fall = sck_fall;
  assign bus.o_cs_start = cs_start;
  assign bus.o_count_f = count_f;
  assign bus.o_rx_byte = rx_byte;
  assign bus.o_rx_valid = rx_valid;
  assign bus.o_busy = busy;
  assign bus.o_frame_err = frame_err;
endmodule
